// File: rtl/reg_swap_sched.sv
// Shared register bank controller: two requesters arbitrate round-robin for
// single-register writes or three-step swaps sequenced through one temp register.
module reg_swap_sched #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic             r0_op,
   input  logic [AW-1:0]    r0_a,
   input  logic [AW-1:0]    r0_b,
   input  logic [WIDTH-1:0] r0_wdata,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic             r1_op,
   input  logic [AW-1:0]    r1_a,
   input  logic [AW-1:0]    r1_b,
   input  logic [WIDTH-1:0] r1_wdata,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             busy,
   output logic             done,
   output logic             done_id
);

   typedef enum logic [2:0] {IDLE, WR, LOAD, MOVE, STORE} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] bank_reg [DEPTH];
   logic [WIDTH-1:0] temp_reg;
   logic             op_reg;
   logic [AW-1:0]    a_reg;
   logic [AW-1:0]    b_reg;
   logic [WIDTH-1:0] wdata_reg;
   logic             id_reg;
   logic             rr_reg;
   logic             done_reg;
   logic             done_id_reg;

   logic             idle;
   logic             grant1;
   logic             accept;
   logic             acc_id;
   logic             acc_op;
   logic [AW-1:0]    acc_a;
   logic [AW-1:0]    acc_b;
   logic [WIDTH-1:0] acc_wdata;

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;

   // Ready is masked while rst is high, even though the state already reads IDLE.
   assign idle   = (state_reg == IDLE) && !rst;
   assign grant1 = r1_valid && (!r0_valid || rr_reg);

   assign r0_ready = idle && r0_valid && !grant1;
   assign r1_ready = idle && r1_valid && grant1;

   assign accept    = r0_ready || r1_ready;
   assign acc_id    = r1_ready;
   assign acc_op    = acc_id ? r1_op    : r0_op;
   assign acc_a     = acc_id ? r1_a     : r0_a;
   assign acc_b     = acc_id ? r1_b     : r0_b;
   assign acc_wdata = acc_id ? r1_wdata : r0_wdata;

   // Exactly one bank register may change per cycle; this picks which and with what.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = a_reg;
      wr_data = wdata_reg;
      case (state_reg)
         WR: begin
            wr_en = 1'b1;
         end
         MOVE: begin
            wr_en   = 1'b1;
            wr_data = bank_reg[b_reg];
         end
         STORE: begin
            wr_en   = 1'b1;
            wr_addr = b_reg;
            wr_data = temp_reg;
         end
         default: begin
            wr_en = 1'b0;
         end
      endcase
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bank
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               bank_reg[gi] <= '0;
            end else if (wr_en && (wr_addr == AW'(gi))) begin
               bank_reg[gi] <= wr_data;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         temp_reg    <= '0;
         op_reg      <= 1'b0;
         a_reg       <= '0;
         b_reg       <= '0;
         wdata_reg   <= '0;
         id_reg      <= 1'b0;
         rr_reg      <= 1'b0;
         done_reg    <= 1'b0;
         done_id_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  op_reg    <= acc_op;
                  a_reg     <= acc_a;
                  b_reg     <= acc_b;
                  wdata_reg <= acc_wdata;
                  id_reg    <= acc_id;
                  rr_reg    <= !acc_id;
                  state_reg <= acc_op ? LOAD : WR;
               end
            end
            WR: begin
               done_reg    <= 1'b1;
               done_id_reg <= id_reg;
               state_reg   <= IDLE;
            end
            LOAD: begin
               temp_reg  <= bank_reg[a_reg];
               state_reg <= MOVE;
            end
            MOVE: begin
               state_reg <= STORE;
            end
            STORE: begin
               done_reg    <= 1'b1;
               done_id_reg <= id_reg;
               state_reg   <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign rd_data = bank_reg[rd_addr];
   assign busy    = (state_reg != IDLE);
   assign done    = done_reg;
   assign done_id = done_id_reg;

endmodule

// File: tb/tb_reg_swap_sched.sv
// Self-checking bench for reg_swap_sched: directed vector table, hand-written
// corner sequences and a randomized run against a timing-level bank model.
module tb_reg_swap_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       r0_valid, r0_ready, r0_op;
   logic [1:0] r0_a, r0_b;
   logic [3:0] r0_wdata;
   logic       r1_valid, r1_ready, r1_op;
   logic [1:0] r1_a, r1_b;
   logic [3:0] r1_wdata;
   logic [1:0] rd_addr;
   logic [3:0] rd_data;
   logic       busy, done, done_id;

   reg_swap_sched #(.WIDTH(4), .DEPTH(4), .AW(2)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op),
      .r0_a(r0_a), .r0_b(r0_b), .r0_wdata(r0_wdata),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op),
      .r1_a(r1_a), .r1_b(r1_b), .r1_wdata(r1_wdata),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .busy(busy), .done(done), .done_id(done_id)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
      $fatal(1);
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Requester stimulus held as plain ints, copied to the ports by drive().
   int rv[2], rop[2], ra[2], rb[2], rwd[2];

   task automatic drive();
      r0_valid = (rv[0] != 0); r0_op = (rop[0] != 0);
      r0_a = 2'(ra[0]); r0_b = 2'(rb[0]); r0_wdata = 4'(rwd[0]);
      r1_valid = (rv[1] != 0); r1_op = (rop[1] != 0);
      r1_a = 2'(ra[1]); r1_b = 2'(rb[1]); r1_wdata = 4'(rwd[1]);
   endtask

   task automatic clr();
      for (int i = 0; i < 2; i++) begin
         rv[i] = 0; rop[i] = 0; ra[i] = 0; rb[i] = 0; rwd[i] = 0;
      end
      drive();
   endtask

   task automatic do_op(input int id, input int op, input int a, input int b, input int wd);
      bit got;
      got = 0;
      rv[id] = 1; rop[id] = op; ra[id] = a; rb[id] = b; rwd[id] = wd;
      drive();
      for (int k = 0; k < 20; k++) begin
         #1;
         if ((id == 0 && r0_ready) || (id == 1 && r1_ready)) begin
            got = 1;
            break;
         end
         tick();
      end
      if (!got) chk("op_accept_timeout", 0, 1);
      $display("txn: req%0d op=%0d a=%0d b=%0d wd=%0d", id, op, a, b, wd);
      tick();
      rv[id] = 0;
      drive();
   endtask

   typedef struct {
      int v0, op0, a0, b0, wd0;
      int v1, op1, a1, b1, wd1;
      int rd;
      int e_rdy0, e_rdy1, e_busy, e_done, e_did, e_rd;
   } vec_t;

   function automatic vec_t mk(input int v0, op0, a0, b0, wd0,
                               input int v1, op1, a1, b1, wd1,
                               input int rd, e0, e1, eb, ed, edi, erd);
      vec_t t;
      t.v0 = v0; t.op0 = op0; t.a0 = a0; t.b0 = b0; t.wd0 = wd0;
      t.v1 = v1; t.op1 = op1; t.a1 = a1; t.b1 = b1; t.wd1 = wd1;
      t.rd = rd; t.e_rdy0 = e0; t.e_rdy1 = e1; t.e_busy = eb;
      t.e_done = ed; t.e_did = edi; t.e_rd = erd;
      return t;
   endfunction

   vec_t tv[20];

   typedef struct {int at; int addr; int data;} ev_t;
   ev_t evq[$];
   int  mbank[4];

   initial begin
      int cyc, free_at, done_at, done_idm, rr, g;
      bit idle;

      // Reset state, with both requesters valid to prove ready is masked.
      clr();
      rv[0] = 1; rv[1] = 1; drive();
      rd_addr = 2'd0;
      rst = 1'b1;
      tick(); tick();
      chk("rst_r0_ready", r0_ready, 0);
      chk("rst_r1_ready", r1_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_done_id", done_id, 0);
      chk("rst_rd_data", rd_data, 0);
      clr();
      rst = 1'b0;

      // Per-cycle vectors: write/preload, r1 swap with r0 waiting, swap a==b.
      tv[0]  = mk(1,0,1,0,9, 0,0,0,0,0, 1, 1,0,0,0,0,0);
      tv[1]  = mk(0,0,0,0,0, 0,0,0,0,0, 1, 0,0,1,0,0,0);
      tv[2]  = mk(1,0,0,0,3, 0,0,0,0,0, 1, 1,0,0,1,0,9);
      tv[3]  = mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0,1,0,0,0);
      tv[4]  = mk(1,0,2,0,5, 0,0,0,0,0, 0, 1,0,0,1,0,3);
      tv[5]  = mk(0,0,0,0,0, 0,0,0,0,0, 2, 0,0,1,0,0,0);
      tv[6]  = mk(0,0,0,0,0, 1,1,0,2,0, 2, 0,1,0,1,0,5);
      tv[7]  = mk(1,0,3,0,7, 0,0,0,0,0, 0, 0,0,1,0,0,3);
      tv[8]  = mk(1,0,3,0,7, 0,0,0,0,0, 0, 0,0,1,0,0,3);
      tv[9]  = mk(1,0,3,0,7, 0,0,0,0,0, 0, 0,0,1,0,0,5);
      tv[10] = mk(1,0,3,0,7, 0,0,0,0,0, 2, 1,0,0,1,1,3);
      tv[11] = mk(0,0,0,0,0, 1,1,3,3,0, 3, 0,0,1,0,0,0);
      tv[12] = mk(0,0,0,0,0, 1,1,3,3,0, 3, 0,1,0,1,0,7);
      tv[13] = mk(0,0,0,0,0, 0,0,0,0,0, 3, 0,0,1,0,0,7);
      tv[14] = mk(0,0,0,0,0, 0,0,0,0,0, 3, 0,0,1,0,0,7);
      tv[15] = mk(0,0,0,0,0, 0,0,0,0,0, 3, 0,0,1,0,0,7);
      tv[16] = mk(0,0,0,0,0, 0,0,0,0,0, 3, 0,0,0,1,1,7);
      tv[17] = mk(0,0,0,0,0, 0,0,0,0,0, 0, 0,0,0,0,0,5);
      tv[18] = mk(0,0,0,0,0, 0,0,0,0,0, 1, 0,0,0,0,0,9);
      tv[19] = mk(0,0,0,0,0, 0,0,0,0,0, 2, 0,0,0,0,0,3);

      for (int i = 0; i < 20; i++) begin
         rv[0] = tv[i].v0; rop[0] = tv[i].op0; ra[0] = tv[i].a0; rb[0] = tv[i].b0; rwd[0] = tv[i].wd0;
         rv[1] = tv[i].v1; rop[1] = tv[i].op1; ra[1] = tv[i].a1; rb[1] = tv[i].b1; rwd[1] = tv[i].wd1;
         drive();
         rd_addr = 2'(tv[i].rd);
         #1;
         chk($sformatf("row%0d_r0_ready", i), r0_ready, tv[i].e_rdy0);
         chk($sformatf("row%0d_r1_ready", i), r1_ready, tv[i].e_rdy1);
         chk($sformatf("row%0d_busy", i), busy, tv[i].e_busy);
         chk($sformatf("row%0d_done", i), done, tv[i].e_done);
         if (tv[i].e_done != 0) chk($sformatf("row%0d_done_id", i), done_id, tv[i].e_did);
         chk($sformatf("row%0d_rd_data", i), rd_data, tv[i].e_rd);
         tick();
      end

      // Both requesters valid continuously: grants alternate, two cycles apart.
      for (int k = 0; k < 9; k++) begin
         rv[0] = 1; rop[0] = 0; ra[0] = 0; rwd[0] = 10;
         rv[1] = 1; rop[1] = 0; ra[1] = 1; rwd[1] = 11;
         drive();
         #1;
         chk($sformatf("alt%0d_r0_ready", k), r0_ready, (k % 2 == 0 && (k / 2) % 2 == 0) ? 1 : 0);
         chk($sformatf("alt%0d_r1_ready", k), r1_ready, (k % 2 == 0 && (k / 2) % 2 == 1) ? 1 : 0);
         chk($sformatf("alt%0d_done", k), done, (k >= 2 && k % 2 == 0) ? 1 : 0);
         if (k >= 2 && k % 2 == 0) chk($sformatf("alt%0d_done_id", k), done_id, ((k / 2) - 1) % 2);
         tick();
      end
      clr();
      #1;
      chk("alt_tail_busy", busy, 1);
      chk("alt_tail_done", done, 0);
      tick();
      chk("alt_last_done", done, 1);
      chk("alt_last_done_id", done_id, 0);
      rd_addr = 2'd0; #1;
      chk("alt_bank0", rd_data, 10);
      rd_addr = 2'd1; #1;
      chk("alt_bank1", rd_data, 11);

      // Reset asserted during MOVE of a swap between 4 and 6.
      do_op(0, 0, 0, 0, 4);
      do_op(0, 0, 1, 0, 6);
      do_op(0, 1, 0, 1, 0);
      tick();
      rd_addr = 2'd0; #1;
      chk("move_bank0_old", rd_data, 4);
      chk("move_busy", busy, 1);
      rv[0] = 1; rop[0] = 0; ra[0] = 2; rwd[0] = 5; drive();
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_r0_ready", r0_ready, 0);
      chk("midrst_done", done, 0);
      for (int a = 0; a < 4; a++) begin
         rd_addr = 2'(a); #1;
         chk($sformatf("midrst_bank%0d", a), rd_data, 0);
      end
      tick();
      chk("midrst_hold_busy", busy, 0);
      chk("midrst_hold_done", done, 0);
      rst = 1'b0;
      #1;
      chk("postrst_r0_ready", r0_ready, 1);
      chk("postrst_done", done, 0);
      tick();
      clr();
      #1;
      chk("postrst_wr_busy", busy, 1);
      chk("postrst_wr_done", done, 0);
      tick();
      chk("postrst_done_pulse", done, 1);
      chk("postrst_done_id", done_id, 0);
      rd_addr = 2'd2; #1;
      chk("postrst_bank2", rd_data, 5);
      rd_addr = 2'd1; #1;
      chk("postrst_bank1", rd_data, 0);

      // Randomized traffic against a model of when each bank update becomes visible.
      clr();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cyc = 0; free_at = 0; done_at = -1; done_idm = 0; rr = 0;
      for (int i = 0; i < 4; i++) mbank[i] = 0;
      evq.delete();
      for (int n = 0; n < 600; n++) begin
         while (evq.size() > 0 && evq[0].at == cyc) begin
            mbank[evq[0].addr] = evq[0].data;
            void'(evq.pop_front());
         end
         for (int i = 0; i < 2; i++) begin
            if (rv[i] == 0 && $urandom_range(1, 0) == 1) begin
               rv[i] = 1;
               rop[i] = $urandom_range(1, 0);
               ra[i] = $urandom_range(3, 0);
               rb[i] = $urandom_range(3, 0);
               rwd[i] = $urandom_range(15, 0);
            end
         end
         drive();
         rd_addr = 2'($urandom_range(3, 0));
         #1;
         idle = (cyc >= free_at);
         g = -1;
         if (idle) begin
            if (rv[0] != 0 && rv[1] != 0) g = rr;
            else if (rv[0] != 0) g = 0;
            else if (rv[1] != 0) g = 1;
         end
         chk("rnd_r0_ready", r0_ready, (g == 0) ? 1 : 0);
         chk("rnd_r1_ready", r1_ready, (g == 1) ? 1 : 0);
         chk("rnd_busy", busy, idle ? 0 : 1);
         chk("rnd_done", done, (cyc == done_at) ? 1 : 0);
         if (cyc == done_at) chk("rnd_done_id", done_id, done_idm);
         chk("rnd_rd_data", rd_data, mbank[int'(rd_addr)]);
         if (g >= 0) begin
            if (rop[g] == 0) begin
               evq.push_back('{cyc + 2, ra[g], rwd[g]});
               done_at = cyc + 2;
            end else begin
               evq.push_back('{cyc + 3, ra[g], mbank[rb[g]]});
               evq.push_back('{cyc + 4, rb[g], mbank[ra[g]]});
               done_at = cyc + 4;
            end
            free_at = done_at;
            done_idm = g;
            rr = 1 - g;
            $display("txn %0d: req%0d op=%0d a=%0d b=%0d wd=%0d", cyc, g, rop[g], ra[g], rb[g], rwd[g]);
         end
         tick();
         cyc++;
         if (g >= 0) rv[g] = 0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_swap_sched.md
Name: reg_swap_sched

Overview:
- Controller for a small shared register bank that two requesters use for writes and register-exchange operations.
- Each swap is sequenced through a single temp register in three steps: temp<=A, A<=B, B<=temp. No two registers are ever updated in the same cycle.
- A round-robin arbiter shares the bank between the requesters. A combinational read port gives visibility into the bank.
- Sits between requester logic and the register datapath.

Parameters:
WIDTH, 4, bit width of each bank register and of temp
DEPTH, 4, number of bank registers; must equal 2**AW
AW, 2, address width

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  reset, asynchronous and active-high
r0_valid  in  1  requester 0 request valid
r0_ready  out  1  requester 0 request accepted this cycle
r0_op  in  1  0=write, 1=swap
r0_a  in  AW  write address / swap operand A
r0_b  in  AW  swap operand B (ignored for write)
r0_wdata  in  WIDTH  write data
r1_valid, r1_ready, r1_op, r1_a, r1_b, r1_wdata  same as requester 0, for requester 1
rd_addr  in  AW  read address
rd_data  out  WIDTH  bank[rd_addr], combinational
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse: operation complete, bank holds final values
done_id  out  1  requester whose operation completed (valid when done=1)

Behaviour:
- Reset (async, rst=1):
  - State -> IDLE.
  - All bank registers, temp and latched request -> 0.
  - RR pointer -> requester 0.
  - busy=0, done=0, done_id=0; r0_ready=r1_ready=0 while rst high.
  - rd_data reads 0.
  - Reset mid-operation aborts it: no done pulse, and partial swap results are discarded because the bank is cleared.
- States: IDLE, WR, LOAD, MOVE, STORE.
- Arbitration, in IDLE only:
  - Grant goes to the valid requester. If both are valid, grant goes to the one the RR pointer names.
  - rX_ready = (state==IDLE) & rX_valid & granted(X), combinational. At most one ready is high per cycle.
  - Never ready outside IDLE.
  - On accept (valid & ready at an edge): latch op/a/b/wdata and the requester id; the RR pointer moves to the other requester.
  - A lone requester may be granted back-to-back.
- Requester rules: hold valid and all fields stable until ready; valid may not drop before acceptance.
- Transitions:
  - IDLE -> WR on an accepted write; IDLE -> LOAD on an accepted swap.
  - WR: bank[a] <= wdata at the end of the cycle; -> IDLE.
  - LOAD: temp <= bank[a]; -> MOVE.
  - MOVE: bank[a] <= bank[b]; -> STORE.
  - STORE: bank[b] <= temp; -> IDLE.
- done: registered. It is 1 in the cycle after the final bank write (the first IDLE cycle) with the latched done_id. A new request may be accepted in that same cycle.
- Latency from the accept edge to the done cycle: write 1 cycle, swap 3 cycles.
- Accept-to-accept throughput: write every 2 cycles, swap every 4 cycles.
- Intermediate bank states are visible on rd_data. After MOVE, bank[a]==bank[b] until STORE completes.
- Boundary cases:
  - Swap with a==b: all three steps run, the value is unchanged, done still pulses.
  - rd_addr equal to the address being written: rd_data shows the old value until the edge, the new value after it.
  - No valid in IDLE: stay in IDLE, pointer unchanged.
  - temp is internal and is never cleared except by reset.

Test Plan:
- Reset, then write r0 a=1 wdata=9 -> r0_ready=1 one cycle; done=1, done_id=0 one cycle later; rd_addr=1 reads 9.
- Preload bank[0]=3, bank[2]=5; r1 swap a=0 b=2 -> busy for 3 cycles; mid-swap bank[0]=5 and bank[2]=5; after done, bank[0]=5 and bank[2]=3.
- r0 and r1 both valid continuously, writes to addresses 0 and 1 -> grants alternate 0,1,0,1; done_id alternates; accepts 2 cycles apart.
- Swap a=b=3 with bank[3]=7 -> done after 3 cycles; bank[3]=7; other registers unchanged.
- Assert rst in MOVE of a swap between bank values 4 and 6 -> immediately busy=0, all bank=0, no done pulse; a new write is accepted on the first cycle after deassert.
- r1 requests while an r0 swap is in progress -> r1_ready=0 until IDLE, then accepted in the done cycle.
